// File: rtl/bcd_pkg.sv
// Shared BCD constants and nibble helpers for the BCD counter slice.
package bcd_pkg;

    localparam int         BCD_W         = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // True when the nibble is a legal decimal digit (0..9).
    function automatic logic is_valid_bcd(input logic [BCD_W-1:0] nib);
        return (nib <= BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One combinational BCD digit cell: steps a single decimal digit up or down
// and reports the carry (up) or borrow (down) into the next digit.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             step,
    input  logic             dir,
    output logic [BCD_W-1:0] next_digit,
    output logic             carry_borrow
);

    // Increment/decrement with decimal rollover; hold when not stepped.
    always_comb begin
        next_digit   = digit;
        carry_borrow = 1'b0;
        if (step) begin
            if (dir) begin
                if (digit >= BCD_MAX_DIGIT) begin
                    next_digit   = '0;
                    carry_borrow = 1'b1;
                end else begin
                    next_digit = digit + 4'd1;
                end
            end else begin
                if (digit == '0) begin
                    next_digit   = BCD_MAX_DIGIT;
                    carry_borrow = 1'b1;
                end else begin
                    next_digit = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit up/down BCD counter with validated parallel load, wrap or
// saturate at the terminal values, and a separately strobed display register.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int WRAP   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      dir,
    input  logic                      load,
    input  logic [BCD_W*DIGITS-1:0]   load_val,
    input  logic                      upd,
    output logic [BCD_W*DIGITS-1:0]   count,
    output logic                      tc,
    output logic                      load_err
);

    localparam int             W         = BCD_W * DIGITS;
    localparam logic [W-1:0]   ALL_NINES = {DIGITS{BCD_MAX_DIGIT}};

    logic [W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]    count_q, count_d;
    logic            tc_q, tc_d;
    logic            load_err_q, load_err_d;

    logic [W-1:0]    step_val;
    logic [DIGITS:0] chain;
    logic            load_ok;
    logic [W-1:0]    terminal;
    logic            at_term;
    logic            crossing;

    // Digit 0 always steps; each higher digit steps on the carry/borrow below it.
    assign chain[0] = 1'b1;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .digit        (cnt_q[g*BCD_W +: BCD_W]),
                .step         (chain[g]),
                .dir          (dir),
                .next_digit   (step_val[g*BCD_W +: BCD_W]),
                .carry_borrow (chain[g+1])
            );
        end
    endgenerate

    // A load is accepted only if every nibble is a legal decimal digit.
    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_valid_bcd(load_val[i*BCD_W +: BCD_W])) begin
                load_ok = 1'b0;
            end
        end
    end

    // Next live value and flags: load beats enable; terminal handling by WRAP.
    always_comb begin
        terminal   = dir ? ALL_NINES : '0;
        at_term    = (cnt_q == terminal);
        crossing   = chain[DIGITS];
        cnt_d      = cnt_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;

        if (load) begin
            if (load_ok) begin
                cnt_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (crossing && (WRAP == 0)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = step_val;
            end
        end

        if (WRAP != 0) begin
            tc_d = !load && en && crossing;
        end else begin
            tc_d = en && at_term;
        end

        // The display captures the post-edge live value, including loads/steps.
        count_d = upd ? cnt_d : count_q;
    end

    // Live counter and status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    // Display register, refreshed only on the update strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign tc       = tc_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n across four parameterisations.
module tb_bcd_counter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: DIGITS=8, WRAP=1
    logic        a_rst, a_en, a_dir, a_load, a_upd;
    logic [31:0] a_lv, a_count;
    logic        a_tc, a_lerr;
    // Instance B: DIGITS=2, WRAP=1
    logic        b_rst, b_en, b_dir, b_load, b_upd;
    logic [7:0]  b_lv, b_count;
    logic        b_tc, b_lerr;
    // Instance C: DIGITS=2, WRAP=0
    logic        c_rst, c_en, c_dir, c_load, c_upd;
    logic [7:0]  c_lv, c_count;
    logic        c_tc, c_lerr;
    // Instance D: DIGITS=3, WRAP=1
    logic        d_rst, d_en, d_dir, d_load, d_upd;
    logic [11:0] d_lv, d_count;
    logic        d_tc, d_lerr;

    bcd_counter_n #(.DIGITS(8), .WRAP(1)) u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .dir(a_dir), .load(a_load),
        .load_val(a_lv), .upd(a_upd), .count(a_count), .tc(a_tc), .load_err(a_lerr));
    bcd_counter_n #(.DIGITS(2), .WRAP(1)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .dir(b_dir), .load(b_load),
        .load_val(b_lv), .upd(b_upd), .count(b_count), .tc(b_tc), .load_err(b_lerr));
    bcd_counter_n #(.DIGITS(2), .WRAP(0)) u_c (
        .clk(clk), .rst(c_rst), .en(c_en), .dir(c_dir), .load(c_load),
        .load_val(c_lv), .upd(c_upd), .count(c_count), .tc(c_tc), .load_err(c_lerr));
    bcd_counter_n #(.DIGITS(3), .WRAP(1)) u_d (
        .clk(clk), .rst(d_rst), .en(d_en), .dir(d_dir), .load(d_load),
        .load_val(d_lv), .upd(d_upd), .count(d_count), .tc(d_tc), .load_err(d_lerr));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        a_rst = 0; a_en = 0; a_dir = 0; a_load = 0; a_upd = 0; a_lv = '0;
        b_rst = 0; b_en = 0; b_dir = 0; b_load = 0; b_upd = 0; b_lv = '0;
        c_rst = 0; c_en = 0; c_dir = 0; c_load = 0; c_upd = 0; c_lv = '0;
        d_rst = 0; d_en = 0; d_dir = 0; d_load = 0; d_upd = 0; d_lv = '0;

        // Reset state, with load/en/upd active to confirm reset overrides them
        a_load = 1; a_lv = 32'h12345678; a_en = 1; a_upd = 1;
        tick();
        chk("rst_a_count", a_count, 0);
        chk("rst_a_tc",    a_tc,    0);
        chk("rst_a_lerr",  a_lerr,  0);
        chk("rst_b_count", b_count, 0);
        chk("rst_c_count", c_count, 0);
        chk("rst_d_count", d_count, 0);

        // A: count up 12 cycles from 0
        a_rst = 1; a_load = 0; a_en = 1; a_dir = 1; a_upd = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("a_up_tc_low", a_tc, 0);
        end
        chk("a_up12_count", a_count, 32'h00000012);

        // A: load 455, then two steps to 457
        a_load = 1; a_lv = 32'h00000455;
        tick();
        chk("a_load455", a_count, 32'h00000455);
        a_load = 0;
        tick(); tick();
        chk("a_457", a_count, 32'h00000457);

        // A: reset mid-count with a load in the same cycle
        a_rst = 0; a_load = 1; a_lv = 32'h12345678;
        tick();
        chk("a_midrst_count", a_count, 0);
        chk("a_midrst_tc",    a_tc,    0);
        chk("a_midrst_lerr",  a_lerr,  0);
        a_rst = 1; a_load = 0;
        tick();
        chk("a_restart", a_count, 32'h00000001);

        // A: wrap from all nines
        a_load = 1; a_lv = 32'h99999998;
        tick();
        chk("a_load_98", a_count, 32'h99999998);
        a_load = 0;
        tick();
        chk("a_99_count", a_count, 32'h99999999);
        chk("a_99_tc",    a_tc,    0);
        tick();
        chk("a_wrap_count", a_count, 32'h00000000);
        chk("a_wrap_tc",    a_tc,    1);
        tick();
        chk("a_post_count", a_count, 32'h00000001);
        chk("a_post_tc",    a_tc,    0);

        // A: direction change takes effect immediately, then down-wrap
        a_dir = 0;
        tick();
        chk("a_dn_count", a_count, 32'h00000000);
        chk("a_dn_tc",    a_tc,    0);
        tick();
        chk("a_dnwrap_count", a_count, 32'h99999999);
        chk("a_dnwrap_tc",    a_tc,    1);

        // B: down from 00, wraps to 99 with tc, then 98, 97
        b_rst = 1; b_en = 1; b_dir = 0; b_upd = 1;
        tick();
        chk("b_99_count", b_count, 8'h99);
        chk("b_99_tc",    b_tc,    1);
        tick();
        chk("b_98_tc", b_tc, 0);
        tick();
        chk("b_97_count", b_count, 8'h97);

        // C: saturating up from 98
        c_rst = 1; c_en = 1; c_dir = 1; c_upd = 1; c_load = 1; c_lv = 8'h98;
        tick();
        chk("c_load_count", c_count, 8'h98);
        chk("c_load_tc",    c_tc,    0);
        c_load = 0;
        tick();
        chk("c_s1_count", c_count, 8'h99);
        chk("c_s1_tc",    c_tc,    0);
        tick();
        chk("c_s2_count", c_count, 8'h99);
        chk("c_s2_tc",    c_tc,    1);
        tick();
        chk("c_s3_count", c_count, 8'h99);
        chk("c_s3_tc",    c_tc,    1);
        c_en = 0;
        tick();
        chk("c_off_count", c_count, 8'h99);
        chk("c_off_tc",    c_tc,    0);
        // C: saturating down at 00
        c_en = 1; c_dir = 0; c_load = 1; c_lv = 8'h00;
        tick();
        chk("c_ld00_count", c_count, 8'h00);
        c_load = 0;
        tick();
        chk("c_dsat_count", c_count, 8'h00);
        chk("c_dsat_tc",    c_tc,    1);

        // D: valid load, then rejected load with the display frozen
        d_rst = 1; d_upd = 1; d_load = 1; d_lv = 12'h123;
        tick();
        chk("d_load123", d_count, 12'h123);
        d_upd = 0; d_lv = 12'h1A3; d_en = 1; d_dir = 1;
        tick();
        chk("d_rej_count", d_count, 12'h123);
        chk("d_rej_lerr",  d_lerr,  1);
        d_load = 0;
        tick();
        chk("d_lerr_clear", d_lerr, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("d_frozen", d_count, 12'h123);
        end
        d_upd = 1;
        tick();
        chk("d_upd_count", d_count, 12'h129);
        // D: rejected load with upd high still refreshes count from unchanged cnt
        d_load = 1; d_lv = 12'hF00;
        tick();
        chk("d_rej_upd_count", d_count, 12'h129);
        chk("d_rej_upd_lerr",  d_lerr,  1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
